multicycle_ctrl_fsm: RTL and testbench

//  Multi-cycle sequencer for the MIPS datapath. Replaces the single-cycle opcode decoder.

---
 rtl/multicycle_ctrl_fsm.sv | 191 +++++++++++++++++++
 tb/tb_multicycle_ctrl_fsm.sv | 341 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle MIPS control sequencer: Moore decode of a state register, with FETCH strobes qualified by mem_ready.
// Optional feature macro: ILLEGAL_TRAP_EN (unknown opcodes lock the FSM in TRAP and raise illegal_op).
module multicycle_ctrl_fsm #(
    parameter int ST_W = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [5:0]      opcode,
    input  logic            mem_ready,
    output logic            PCWrite,
    output logic            PCWriteCond,
    output logic [1:0]      PCSource,
    output logic            IorD,
    output logic            MemRead,
    output logic            MemWrite,
    output logic            IRWrite,
    output logic [1:0]      RegDst,
    output logic [1:0]      MemToReg,
    output logic            RegWrite,
    output logic            ALUSrcA,
    output logic [1:0]      ALUSrcB,
    output logic [2:0]      ALUOp,
    output logic            illegal_op,
    output logic [ST_W-1:0] dbg_state
);

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    typedef enum logic [ST_W-1:0] {
        S_RESET,
        S_FETCH,
        S_DECODE,
        S_MEM_ADDR,
        S_MEM_READ,
        S_MEM_WB,
        S_MEM_WRITE,
        S_R_EXEC,
        S_R_WB,
        S_IMM_EXEC,
        S_IMM_WB,
        S_BRANCH,
        S_JAL
`ifdef ILLEGAL_TRAP_EN
        , S_TRAP
`endif
    } state_t;

    state_t state;
    state_t next_state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
        end else begin
            state <= next_state;
        end
    end

    // TRAP only exits through reset, so decoding illegal_op from it is already sticky.
    always_comb begin
        next_state  = state;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        PCSource    = 2'b00;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 2'b00;
        MemToReg    = 2'b00;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        ALUOp       = 3'b000;
        illegal_op  = 1'b0;

        case (state)
            S_RESET: begin
                next_state = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                if (mem_ready) begin
                    IRWrite    = 1'b1;
                    PCWrite    = 1'b1;
                    next_state = S_DECODE;
                end
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_LW, OP_SW:               next_state = S_MEM_ADDR;
                    OP_R:                       next_state = S_R_EXEC;
                    OP_BEQ:                     next_state = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI:   next_state = S_IMM_EXEC;
                    OP_JAL:                     next_state = S_JAL;
`ifdef ILLEGAL_TRAP_EN
                    default:                    next_state = S_TRAP;
`else
                    default:                    next_state = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADDR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (opcode == OP_LW) begin
                    next_state = S_MEM_READ;
                end else if (opcode == OP_SW) begin
                    next_state = S_MEM_WRITE;
                end else begin
                    next_state = S_FETCH;
                end
            end
            S_MEM_READ: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) next_state = S_MEM_WB;
            end
            S_MEM_WB: begin
                MemToReg   = 2'b01;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_MEM_WRITE: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) next_state = S_FETCH;
            end
            S_R_EXEC: begin
                ALUSrcA    = 1'b1;
                ALUOp      = 3'b010;
                next_state = S_R_WB;
            end
            S_R_WB: begin
                RegDst     = 2'b01;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_IMM_EXEC: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                case (opcode)
                    OP_ANDI: ALUOp = 3'b011;
                    OP_ORI:  ALUOp = 3'b100;
                    default: ALUOp = 3'b000;
                endcase
                next_state = S_IMM_WB;
            end
            S_IMM_WB: begin
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                ALUOp       = 3'b001;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                next_state  = S_FETCH;
            end
            S_JAL: begin
                PCWrite    = 1'b1;
                PCSource   = 2'b10;
                RegDst     = 2'b10;
                MemToReg   = 2'b10;
                RegWrite   = 1'b1;
                next_state = S_FETCH;
            end
`ifdef ILLEGAL_TRAP_EN
            S_TRAP: begin
                illegal_op = 1'b1;
                next_state = S_TRAP;
            end
`endif
            default: begin
                next_state = S_RESET;
            end
        endcase
    end

    assign dbg_state = state;

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Bench for multicycle_ctrl_fsm: a queue-of-steps instruction model checked every cycle, plus directed CPI/strobe pins.
module tb_multicycle_ctrl_fsm;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BAD  = 6'b111111;

    localparam int T_RESET = 0, T_FETCH = 1, T_DECODE = 2, T_ADDR = 3, T_MEMR = 4, T_MEMWB = 5;
    localparam int T_MEMW = 6, T_REXEC = 7, T_RWB = 8, T_IEXEC = 9, T_IWB = 10, T_BR = 11;
    localparam int T_JAL = 12, T_TRAP = 13;

    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic [1:0] PCSource;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic [1:0] RegDst;
        logic [1:0] MemToReg;
        logic       RegWrite;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic [2:0] ALUOp;
        logic       illegal_op;
    } outs_t;

    typedef struct {
        outs_t rdy;
        outs_t stall;
        bit    waits;
        bit    decode;
        bit    stuck;
        int    tag;
    } step_t;

    logic       clk;
    logic       rst_n;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, illegal_op;
    logic [1:0] PCSource, RegDst, MemToReg, ALUSrcB;
    logic [2:0] ALUOp;
    logic [3:0] dbg_state;
    outs_t      act;

    int n_cmp  = 0;
    int n_fail = 0;
    int cycle  = 0;

    step_t q[$];
    outs_t rec[64];

    multicycle_ctrl_fsm #(.ST_W(4)) dut (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUOp(ALUOp), .illegal_op(illegal_op), .dbg_state(dbg_state)
    );

    assign act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite,
                  RegDst, MemToReg, RegWrite, ALUSrcA, ALUSrcB, ALUOp, illegal_op};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int got, input int want);
        n_cmp++;
        if (got != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic step_t base(input int tag);
        step_t s;
        s.rdy    = '0;
        s.stall  = '0;
        s.waits  = 1'b0;
        s.decode = 1'b0;
        s.stuck  = 1'b0;
        s.tag    = tag;
        return s;
    endfunction

    function automatic void fin(input step_t s);
        step_t t = s;
        t.stall = t.rdy;
        q.push_back(t);
    endfunction

    function automatic void push_fetch_decode();
        step_t s;
        s = base(T_FETCH);
        s.waits           = 1'b1;
        s.rdy.MemRead     = 1'b1;
        s.rdy.ALUSrcB     = 2'b01;
        s.stall           = s.rdy;
        s.rdy.IRWrite     = 1'b1;
        s.rdy.PCWrite     = 1'b1;
        q.push_back(s);
        s = base(T_DECODE);
        s.decode      = 1'b1;
        s.rdy.ALUSrcB = 2'b11;
        fin(s);
    endfunction

    // Remaining steps of an instruction, decided from the opcode seen in DECODE.
    function automatic void push_exec(input logic [5:0] op);
        step_t s;
        case (op)
            OP_LW, OP_SW: begin
                s = base(T_ADDR); s.rdy.ALUSrcA = 1'b1; s.rdy.ALUSrcB = 2'b10; fin(s);
                if (op == OP_LW) begin
                    s = base(T_MEMR); s.waits = 1'b1; s.rdy.MemRead = 1'b1; s.rdy.IorD = 1'b1; fin(s);
                    s = base(T_MEMWB); s.rdy.MemToReg = 2'b01; s.rdy.RegWrite = 1'b1; fin(s);
                end else begin
                    s = base(T_MEMW); s.waits = 1'b1; s.rdy.MemWrite = 1'b1; s.rdy.IorD = 1'b1; fin(s);
                end
            end
            OP_R: begin
                s = base(T_REXEC); s.rdy.ALUSrcA = 1'b1; s.rdy.ALUOp = 3'b010; fin(s);
                s = base(T_RWB); s.rdy.RegDst = 2'b01; s.rdy.RegWrite = 1'b1; fin(s);
            end
            OP_ADDI, OP_ANDI, OP_ORI: begin
                s = base(T_IEXEC); s.rdy.ALUSrcA = 1'b1; s.rdy.ALUSrcB = 2'b10;
                s.rdy.ALUOp = (op == OP_ANDI) ? 3'b011 : (op == OP_ORI) ? 3'b100 : 3'b000;
                fin(s);
                s = base(T_IWB); s.rdy.RegWrite = 1'b1; fin(s);
            end
            OP_BEQ: begin
                s = base(T_BR); s.rdy.ALUSrcA = 1'b1; s.rdy.ALUOp = 3'b001;
                s.rdy.PCWriteCond = 1'b1; s.rdy.PCSource = 2'b01; fin(s);
            end
            OP_JAL: begin
                s = base(T_JAL); s.rdy.PCWrite = 1'b1; s.rdy.PCSource = 2'b10; s.rdy.RegDst = 2'b10;
                s.rdy.MemToReg = 2'b10; s.rdy.RegWrite = 1'b1; fin(s);
            end
            default: begin
`ifdef ILLEGAL_TRAP_EN
                s = base(T_TRAP); s.stuck = 1'b1; s.rdy.illegal_op = 1'b1; fin(s);
`endif
            end
        endcase
    endfunction

    // Per-cycle comparison against the model, then advance the model by one clock.
    always @(negedge clk) begin
        step_t cur;
        outs_t exp;
        cycle++;
        if (!rst_n) begin
            check("outputs_in_reset", int'(act), 0);
            q.delete();
            q.push_back(base(T_RESET));
        end else begin
            cur = q[0];
            exp = mem_ready ? cur.rdy : cur.stall;
            n_cmp++;
            if (act !== exp) begin
                n_fail++;
                $display("[TB] FAIL cycle_outputs step=%0d cycle=%0d: got %b, want %b",
                         cur.tag, cycle, act, exp);
            end
            if (!cur.stuck && !(cur.waits && !mem_ready)) begin
                void'(q.pop_front());
                if (cur.decode) push_exec(opcode);
                if (q.size() == 0) push_fetch_decode();
            end
        end
    end

    task automatic applyStimulus_sync();
        for (int k = 0; k < 30; k++) begin
            if (q[0].tag == T_FETCH) break;
            mem_ready = 1'b1;
            @(posedge clk); #1;
        end
        check("sync_to_fetch", int'(q[0].tag == T_FETCH), 1);
    endtask

    // Runs one instruction from its FETCH cycle; records outputs per cycle.
    task automatic applyStimulus(input logic [5:0] op, input int stalls,
                                 output int cyc, output int memw, output int regw,
                                 output int pcc, output bit done);
        int left = stalls;
        cyc = 0; memw = 0; regw = 0; pcc = 0; done = 1'b0;
        opcode = op;
        for (int k = 0; k < 40; k++) begin
            if (q[0].waits && q[0].tag != T_FETCH && left > 0) begin
                mem_ready = 1'b0;
                left--;
            end else begin
                mem_ready = 1'b1;
            end
            @(negedge clk);
            rec[cyc] = act;
            cyc++;
            if (MemWrite)    memw++;
            if (RegWrite)    regw++;
            if (PCWriteCond) pcc++;
            @(posedge clk); #1;
            if (q[0].tag == T_FETCH) begin
                done = 1'b1;
                break;
            end
        end
    endtask

    function automatic logic [5:0] pick_op();
        int r;
`ifdef ILLEGAL_TRAP_EN
        r = $urandom_range(0, 7);
`else
        r = $urandom_range(0, 9);
`endif
        case (r)
            0: return OP_LW;
            1: return OP_SW;
            2: return OP_R;
            3: return OP_BEQ;
            4: return OP_ADDI;
            5: return OP_ANDI;
            6: return OP_ORI;
            7: return OP_JAL;
            8: return OP_BAD;
            default: return 6'($urandom_range(0, 63));
        endcase
    endfunction

    initial begin
        int  cyc, memw, regw, pcc;
        bit  done;
        rst_n     = 1'b0;
        opcode    = OP_R;
        mem_ready = 1'b0;
        q.push_back(base(T_RESET));
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        applyStimulus_sync();

        applyStimulus(OP_LW, 0, cyc, memw, regw, pcc, done);
        check("lw_done", int'(done), 1);
        check("lw_cpi", cyc, 5);
        check("lw_regwrite_cycles", regw, 1);
        check("lw_c5_regwrite", int'(rec[4].RegWrite), 1);
        check("lw_c5_memtoreg", int'(rec[4].MemToReg), 1);

        applyStimulus(OP_SW, 3, cyc, memw, regw, pcc, done);
        check("sw_done", int'(done), 1);
        check("sw_cycles", cyc, 7);
        check("sw_memwrite_cycles", memw, 4);
        check("sw_regwrite_cycles", regw, 0);

        applyStimulus(OP_R, 0, cyc, memw, regw, pcc, done);
        check("r_cpi", cyc, 4);
        check("r_exec_aluop", int'(rec[2].ALUOp), 2);

        applyStimulus(OP_BEQ, 0, cyc, memw, regw, pcc, done);
        check("beq_cpi", cyc, 3);
        check("beq_pcwritecond_cycles", pcc, 1);
        check("beq_pcsource", int'(rec[2].PCSource), 1);
        check("beq_aluop", int'(rec[2].ALUOp), 1);

        applyStimulus(OP_JAL, 0, cyc, memw, regw, pcc, done);
        check("jal_cpi", cyc, 3);
        check("jal_vector", int'(rec[2]), int'(20'b1_0_10_0_0_0_0_10_10_1_0_00_000_0));

        applyStimulus(OP_ADDI, 0, cyc, memw, regw, pcc, done);
        check("addi_aluop", int'(rec[2].ALUOp), 0);
        applyStimulus(OP_ANDI, 0, cyc, memw, regw, pcc, done);
        check("andi_aluop", int'(rec[2].ALUOp), 3);
        applyStimulus(OP_ORI, 0, cyc, memw, regw, pcc, done);
        check("ori_aluop", int'(rec[2].ALUOp), 4);
        check("ori_cpi", cyc, 4);

`ifndef ILLEGAL_TRAP_EN
        applyStimulus(OP_BAD, 0, cyc, memw, regw, pcc, done);
        check("illegal_back_to_fetch", int'(done), 1);
        check("illegal_cycles", cyc, 2);
        check("illegal_regwrite", regw, 0);
        check("illegal_memwrite", memw, 0);
        check("illegal_flag", int'(rec[1].illegal_op), 0);
`endif

        // Asynchronous reset in the middle of a stalled store.
        opcode = OP_SW;
        for (int k = 0; k < 20; k++) begin
            mem_ready = (q[0].tag == T_FETCH);
            if (q[0].tag == T_MEMW) break;
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("sw_memwrite_before_reset", int'(MemWrite), 1);
        #2 rst_n = 1'b0;
        #1;
        check("reset_memwrite_immediate", int'(MemWrite), 0);
        check("reset_outputs_immediate", int'(act), 0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n     = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        check("reset_state_after_release", int'(act), 0);
        @(negedge clk);
        check("fetch_after_reset", int'(MemRead), 1);
        @(posedge clk); #1;

        for (int k = 0; k < 3000; k++) begin
            if (q[0].tag == T_FETCH) opcode = pick_op();
            mem_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end

`ifdef ILLEGAL_TRAP_EN
        applyStimulus_sync();
        applyStimulus(OP_BAD, 0, cyc, memw, regw, pcc, done);
        check("trap_stuck", int'(done), 0);
        check("trap_flag", int'(rec[2].illegal_op), 1);
        check("trap_flag_sticky", int'(illegal_op), 1);
        check("trap_no_regwrite", regw, 0);
        #2 rst_n = 1'b0;
        #1;
        check("trap_flag_cleared_by_reset", int'(illegal_op), 0);
        @(posedge clk); #1 rst_n = 1'b1;
        @(negedge clk);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
